max_pool_scheduler: RTL

//  Round-robin scheduler sharing one max_pool2d engine among NREQ requesters.

---
 rtl/max_pool_scheduler_if.sv | 43 ++++
 rtl/max_pool_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/max_pool_scheduler_if.sv
// Requester/engine handshake bundle for max_pool_scheduler.
//   req            requester -> scheduler, level request per requester
//   gnt            scheduler -> requester, one-hot grant held for the job
//   done           scheduler -> requester, 1-cycle completion pulse
//   done_err       scheduler -> requester, 1-cycle pulse with done on abort
//   pool_sel       scheduler -> engine mux, index of granted requester
//   pool_valid_in  scheduler -> engine, 1-cycle start pulse
//   pool_valid_out engine -> scheduler, result valid level
interface max_pool_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             done_err;
  logic [IDX_W-1:0] pool_sel;
  logic             pool_valid_in;
  logic             pool_valid_out;

  // Scheduler side
  modport master (
    input  req,
    input  pool_valid_out,
    output gnt,
    output done,
    output done_err,
    output pool_sel,
    output pool_valid_in
  );

  // Requester/engine side
  modport slave (
    output req,
    output pool_valid_out,
    input  gnt,
    input  done,
    input  done_err,
    input  pool_sel,
    input  pool_valid_in
  );
endinterface

// File: rtl/max_pool_scheduler.sv
// Round-robin scheduler sharing one max_pool2d engine among NREQ requesters.
// Grants one requester per job, drives the engine operand-mux select, pulses
// the engine start, detects completion on a rising valid_out and returns a
// per-requester done pulse. A watchdog aborts jobs that never complete.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          max_pool_scheduler_if.master (req/gnt/done/done_err,
//                pool_sel/pool_valid_in/pool_valid_out)
//   busy         high whenever a job is in flight (state != IDLE)
//   timeout_err  sticky abort flag, cleared only by rst
//   job_count    jobs completed without error, wrapping
module max_pool_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  max_pool_scheduler_if.master  bus,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      job_count
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              vout_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              done_err_q;
  logic [IDX_W-1:0]  pool_sel_q;
  logic              pool_valid_in_q;

  logic [IDX_W-1:0]  winner_c;
  logic              any_req_c;
  logic              vout_rise_c;
  logic [IDX_W-1:0]  next_ptr_c;

  // Only a fresh rising edge of valid_out marks completion; a held level does not
  assign vout_rise_c = bus.pool_valid_out & ~vout_q;

  // Pointer to the requester after the one just served
  assign next_ptr_c = (32'(pool_sel_q) == (NREQ - 1)) ? '0 : pool_sel_q + IDX_W'(1);

  // Round-robin arbiter: first set req scanning from rr_ptr upward, wrapping
  always_comb begin
    int unsigned idx;
    winner_c  = rr_ptr;
    any_req_c = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req_c && bus.req[IDX_W'(idx)]) begin
        winner_c  = IDX_W'(idx);
        any_req_c = 1'b1;
      end
    end
  end

  // Job FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      wait_cnt        <= '0;
      vout_q          <= 1'b0;
      gnt_q           <= '0;
      done_q          <= '0;
      done_err_q      <= 1'b0;
      pool_sel_q      <= '0;
      pool_valid_in_q <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      job_count       <= '0;
    end else begin
      vout_q <= bus.pool_valid_out;
      case (state)
        S_IDLE: begin
          if (any_req_c) begin
            state           <= S_ISSUE;
            gnt_q           <= NREQ'(1) << winner_c;
            pool_sel_q      <= winner_c;
            pool_valid_in_q <= 1'b1;
            busy            <= 1'b1;
          end
        end
        S_ISSUE: begin
          pool_valid_in_q <= 1'b0;
          wait_cnt        <= '0;
          state           <= S_WAIT;
        end
        S_WAIT: begin
          if (vout_rise_c) begin
            state  <= S_DONE;
            done_q <= NREQ'(1) << pool_sel_q;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state      <= S_DONE;
            done_q     <= NREQ'(1) << pool_sel_q;
            done_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DONE: begin
          // done_err_q distinguishes abort from normal completion here
          if (done_err_q) timeout_err <= 1'b1;
          else            job_count   <= job_count + CNT_W'(1);
          done_q     <= '0;
          done_err_q <= 1'b0;
          gnt_q      <= '0;
          busy       <= 1'b0;
          rr_ptr     <= next_ptr_c;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.done_err      = done_err_q;
  assign bus.pool_sel      = pool_sel_q;
  assign bus.pool_valid_in = pool_valid_in_q;

endmodule
